r88_prefetch: RTL

// - Instruction prefetch stage upstream of the instruction decoder: fetches opcode/operand

---
 rtl/r88_prefetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/r88_prefetch.sv
// Instruction prefetch stage: fetches bytes at the fetch PC into a small FIFO for the decoder.
// Define R88_PREFETCH_PEEK_EN to expose the second-oldest byte and a two-byte pop.
module r88_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        sysClock,
  input  logic        sysResetN,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memAck,
  input  logic [7:0]  memData,
  input  logic        flush,
  input  logic [15:0] flushAddr,
  output logic        opValid,
  output logic [7:0]  opByte,
  output logic [15:0] opAddr,
  input  logic        opTake,
`ifdef R88_PREFETCH_PEEK_EN
  output logic        peekValid,
  output logic [7:0]  peekByte,
  input  logic        opTake2,
`endif
  output logic [3:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} stateE;

  stateE             state;
  logic [15:0]       pc;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [7:0]        dataMem [DEPTH];
  logic [15:0]       addrMem [DEPTH];

  logic              push;
  logic [CNT_W-1:0]  popCnt;
  logic [CNT_W-1:0]  keptCnt;
  logic [CNT_W-1:0]  newCnt;
  logic [PTR_W-1:0]  headPtr;
  logic [7:0]        headByte;
  logic [15:0]       headAddr;
  logic [15:0]       pcNext;
`ifdef R88_PREFETCH_PEEK_EN
  logic [PTR_W-1:0]  secPtr;
  logic [7:0]        secByte;
`endif

  // Post-update FIFO view: what the head (and second entry) will be after this edge.
  always_comb begin
    popCnt = '0;
`ifdef R88_PREFETCH_PEEK_EN
    if (opTake2 && peekValid) popCnt = CNT_W'(2);
    else if (opTake && opValid) popCnt = CNT_W'(1);
`else
    if (opTake && opValid) popCnt = CNT_W'(1);
`endif
    push    = (state == WAIT) && memAck && !flush;
    keptCnt = count - popCnt;
    newCnt  = keptCnt + CNT_W'(push);
    headPtr = rdPtr + PTR_W'(popCnt);
    pcNext  = pc + 16'd1;
    // Nothing left after the pop: the byte arriving this cycle becomes the head.
    if (keptCnt == '0) begin
      headByte = memData;
      headAddr = memAddr;
    end else begin
      headByte = dataMem[headPtr];
      headAddr = addrMem[headPtr];
    end
`ifdef R88_PREFETCH_PEEK_EN
    secPtr  = headPtr + PTR_W'(1);
    secByte = (keptCnt == CNT_W'(1)) ? memData : dataMem[secPtr];
`endif
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge sysClock) begin
    if (push) begin
      dataMem[wrPtr] <= memData;
      addrMem[wrPtr] <= memAddr;
    end
  end

  // Fetch FSM, FIFO pointers and registered decoder-side outputs.
  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      memReq   <= 1'b0;
      memAddr  <= RESET_ADDR;
      opValid  <= 1'b0;
      opByte   <= 8'h00;
      opAddr   <= 16'h0000;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
`ifdef R88_PREFETCH_PEEK_EN
      peekValid <= 1'b0;
      peekByte  <= 8'h00;
`endif
    end else if (flush) begin
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      opValid <= 1'b0;
      pc      <= flushAddr;
`ifdef R88_PREFETCH_PEEK_EN
      peekValid <= 1'b0;
`endif
      // Memory cannot abort: an unanswered request is left to complete in DROP.
      case (state)
        WAIT, DROP: begin
          if (memAck) begin
            state   <= WAIT;
            memReq  <= 1'b1;
            memAddr <= flushAddr;
          end else begin
            state <= DROP;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end else begin
      count   <= newCnt;
      rdPtr   <= headPtr;
      opValid <= (newCnt != '0);
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (newCnt != '0) begin
        opByte <= headByte;
        opAddr <= headAddr;
      end
`ifdef R88_PREFETCH_PEEK_EN
      peekValid <= (newCnt >= CNT_W'(2));
      if (newCnt >= CNT_W'(2)) peekByte <= secByte;
`endif
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state   <= WAIT;
            memReq  <= 1'b1;
            memAddr <= pc;
          end
        end
        WAIT: begin
          if (memAck) begin
            pc <= pcNext;
            if (newCnt < DEPTH_C) begin
              memAddr <= pcNext;
            end else begin
              state  <= IDLE;
              memReq <= 1'b0;
            end
          end
        end
        DROP: begin
          if (memAck) begin
            state   <= WAIT;
            memAddr <= pc;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
